// File: rtl/range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : range_tracker
// Purpose  : Streaming range tracker. Between a go strobe and a finish strobe
//            it accepts samples qualified by data_valid, keeps a running
//            minimum, maximum and saturating sample count, and on finish
//            latches max-min, min, max and count into registered outputs
//            while pulsing done. Protocol violations set a sticky error flag
//            that is cleared only by a clean go.
// Ports    : clock, reset      - rising-edge clock, async active-high reset
//            go, finish        - session start / end strobes
//            data_valid,data_in- sample qualifier and sample
//            range             - max-min of last completed session (unsigned)
//            min_out, max_out  - extremes of last completed session
//            sample_count      - accepted samples, saturating
//            busy              - session active
//            done              - one-cycle pulse when results update
//            error             - sticky protocol-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module range_tracker #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 finish,
  input  logic                 data_valid,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     range,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;

  localparam logic                 c_flip    = (SIGNED != 0);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_acc_min;
  logic [WIDTH-1:0]     r_acc_max;
  logic [CNT_WIDTH-1:0] r_acc_cnt;

  logic                 w_start;
  logic                 w_lt_min;
  logic                 w_gt_max;
  logic                 w_empty;
  logic [WIDTH-1:0]     w_min_nxt;
  logic [WIDTH-1:0]     w_max_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  // Flipping the MSB maps two's-complement order onto unsigned order, so a
  // single unsigned comparator serves both modes.
  function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1] ^ c_flip, v[WIDTH-2:0]};
  endfunction

  assign w_start  = go & ~finish;
  assign w_lt_min = order_key(data_in) < order_key(r_acc_min);
  assign w_gt_max = order_key(data_in) > order_key(r_acc_max);
  // The count saturates but never wraps, so zero means "no sample yet".
  assign w_empty  = (r_acc_cnt == '0);

  // Accumulator values including the current-cycle sample, if any.
  always_comb begin
    w_min_nxt = r_acc_min;
    w_max_nxt = r_acc_max;
    w_cnt_nxt = r_acc_cnt;
    if (data_valid) begin
      if (w_empty || w_lt_min) w_min_nxt = data_in;
      if (w_empty || w_gt_max) w_max_nxt = data_in;
      if (r_acc_cnt != c_cnt_max) w_cnt_nxt = r_acc_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc_min    <= '0;
      r_acc_max    <= '0;
      r_acc_cnt    <= '0;
      range        <= '0;
      min_out      <= '0;
      max_out      <= '0;
      sample_count <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, ERROR: begin
          if (w_start) begin
            // Go cycle may carry the seeding sample.
            r_state   <= ACTIVE;
            busy      <= 1'b1;
            error     <= 1'b0;
            r_acc_min <= data_valid ? data_in : '0;
            r_acc_max <= data_valid ? data_in : '0;
            r_acc_cnt <= data_valid ? c_cnt_one : '0;
          end else if (finish) begin
            r_state <= ERROR;
            error   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (go) begin
            r_state <= ERROR;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else if (finish) begin
            // An empty session leaves the accumulators at zero, which gives
            // the all-zero result without a special case.
            r_state      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            range        <= w_max_nxt - w_min_nxt;
            min_out      <= w_min_nxt;
            max_out      <= w_max_nxt;
            sample_count <= w_cnt_nxt;
            r_acc_min    <= w_min_nxt;
            r_acc_max    <= w_max_nxt;
            r_acc_cnt    <= w_cnt_nxt;
          end else begin
            r_acc_min <= w_min_nxt;
            r_acc_max <= w_max_nxt;
            r_acc_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_tracker
// Purpose  : Directed self-checking bench for range_tracker. Three instances
//            share one stimulus stream: unsigned 8-bit, signed 8-bit, and
//            unsigned 8-bit with a 2-bit saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_tracker;

  logic       clk;
  logic       rst;
  logic       go;
  logic       finish;
  logic       data_valid;
  logic [7:0] data_in;

  logic [7:0] u_range, u_min, u_max, u_cnt;
  logic       u_busy, u_done, u_err;
  logic [7:0] s_range, s_min, s_max, s_cnt;
  logic       s_busy, s_done, s_err;
  logic [7:0] c_range, c_min, c_max;
  logic [1:0] c_cnt;
  logic       c_busy, c_done, c_err;

  int tests = 0;
  int fails = 0;
  int busy_cycles;

  range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(0)) u_uns (
    .clock(clk), .reset(rst), .go(go), .finish(finish),
    .data_valid(data_valid), .data_in(data_in),
    .range(u_range), .min_out(u_min), .max_out(u_max),
    .sample_count(u_cnt), .busy(u_busy), .done(u_done), .error(u_err));

  range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1)) u_sgn (
    .clock(clk), .reset(rst), .go(go), .finish(finish),
    .data_valid(data_valid), .data_in(data_in),
    .range(s_range), .min_out(s_min), .max_out(s_max),
    .sample_count(s_cnt), .busy(s_busy), .done(s_done), .error(s_err));

  range_tracker #(.WIDTH(8), .CNT_WIDTH(2), .SIGNED(0)) u_sat (
    .clock(clk), .reset(rst), .go(go), .finish(finish),
    .data_valid(data_valid), .data_in(data_in),
    .range(c_range), .min_out(c_min), .max_out(c_max),
    .sample_count(c_cnt), .busy(c_busy), .done(c_done), .error(c_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic g, input logic f, input logic v,
                      input logic [7:0] d);
    go = g; finish = f; data_valid = v; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; finish = 1'b0; data_valid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_range", u_range, 0);
    check("rst_cnt",   u_cnt,   0);
    check("rst_flags", {u_busy, u_done, u_err}, 0);
    rst = 1'b0;
    step(0, 0, 0, 8'h00);

    // Unsigned session, go-cycle seed, empty finish.
    busy_cycles = 0;
    step(1, 0, 1, 8'h30); busy_cycles += int'(u_busy);
    check("t1_busy_rise", u_busy, 1);
    step(0, 0, 1, 8'h10); busy_cycles += int'(u_busy);
    step(0, 0, 1, 8'hF0); busy_cycles += int'(u_busy);
    step(0, 0, 1, 8'h55); busy_cycles += int'(u_busy);
    check("t1_no_early_done", u_done, 0);
    step(0, 1, 0, 8'h00); busy_cycles += int'(u_busy);
    check("t1_range", u_range, 8'hE0);
    check("t1_min",   u_min,   8'h10);
    check("t1_max",   u_max,   8'hF0);
    check("t1_cnt",   u_cnt,   4);
    check("t1_done",  u_done,  1);
    check("t1_busy_cycles", busy_cycles, 4);
    step(0, 0, 0, 8'h00);
    check("t1_done_pulse", u_done, 0);

    // Signed ordering; finish cycle carries the last sample.
    step(1, 0, 1, 8'h9C);
    step(0, 0, 1, 8'h1B);
    step(0, 1, 1, 8'h05);
    check("t2_s_min",   s_min,   8'h9C);
    check("t2_s_max",   s_max,   8'h1B);
    check("t2_s_range", s_range, 8'h7F);
    check("t2_s_cnt",   s_cnt,   3);
    check("t2_u_min",   u_min,   8'h05);
    check("t2_u_range", u_range, 8'h97);
    step(0, 0, 0, 8'h00);

    // Finish in IDLE: error, results held; ERROR ignores samples.
    step(0, 1, 0, 8'h00);
    check("t3_err",       s_err,   1);
    check("t3_hold",      s_range, 8'h7F);
    check("t3_no_done",   s_done,  0);
    step(0, 0, 1, 8'h77);
    check("t3_sticky",    s_err,   1);
    check("t3_busy",      s_busy,  0);

    // Recovery from ERROR with a single seeded sample.
    step(1, 0, 1, 8'h22);
    check("t4_err_clr",   u_err,   0);
    check("t4_busy",      u_busy,  1);
    step(0, 1, 0, 8'h00);
    check("t4_range",     u_range, 0);
    check("t4_min",       u_min,   8'h22);
    check("t4_cnt",       u_cnt,   1);
    check("t4_done",      u_done,  1);

    // Go while ACTIVE discards the session.
    step(1, 0, 1, 8'h50);
    step(1, 0, 0, 8'h00);
    check("t5_err",       u_err,   1);
    check("t5_busy",      u_busy,  0);
    check("t5_no_done",   u_done,  0);
    step(0, 1, 1, 8'h60);
    check("t5_no_done2",  u_done,  0);
    check("t5_hold_min",  u_min,   8'h22);

    // Gapped samples, then back-to-back empty session.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h07);
    step(0, 0, 0, 8'hEE);
    step(0, 0, 0, 8'h01);
    step(0, 0, 1, 8'h03);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    check("t6_cnt",       u_cnt,   2);
    check("t6_range",     u_range, 4);
    check("t6_min",       u_min,   8'h03);
    check("t6_max",       u_max,   8'h07);
    step(1, 0, 0, 8'h00);
    check("t6_b2b_busy",  u_busy,  1);
    check("t6_b2b_err",   u_err,   0);
    step(0, 1, 0, 8'h00);
    check("t6_empty_res", {u_range, u_min, u_max, u_cnt}, 0);
    check("t6_empty_done", u_done, 1);

    // Counter saturation with a 2-bit counter.
    step(1, 0, 1, 8'd1);
    for (int i = 2; i <= 5; i++) step(0, 0, 1, 8'(i));
    step(0, 1, 1, 8'd6);
    check("t7_sat_cnt",   c_cnt,   3);
    check("t7_sat_range", c_range, 5);
    check("t7_sat_max",   c_max,   6);
    check("t7_wide_cnt",  u_cnt,   6);

    // Asynchronous reset mid-session.
    step(1, 0, 1, 8'h80);
    step(0, 0, 1, 8'h81);
    step(0, 0, 1, 8'h82);
    rst = 1'b1;
    #1;
    check("t8_rst_res",   {u_range, u_min, u_max, u_cnt}, 0);
    check("t8_rst_flags", {u_busy, u_done, u_err}, 0);
    @(posedge clk);
    #1;
    check("t8_no_done",   u_done,  0);
    rst = 1'b0;
    step(1, 0, 1, 8'h40);
    step(0, 1, 1, 8'h41);
    check("t8_new_range", u_range, 1);
    check("t8_new_cnt",   u_cnt,   2);
    check("t8_new_done",  u_done,  1);
    step(0, 0, 0, 8'h00);
    check("t8_done_clr",  u_done,  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/range_tracker.md
# range_tracker

Parametrised streaming range tracker, the next generation of the chip's range-finding datapath. Between a `go` and a `finish` strobe it qualifies samples with `data_valid` and tracks running minimum, maximum and sample count. On `finish` it latches max−min, min, max and count into registered result outputs and pulses `done`. It supports signed or unsigned data, reports protocol violations on a sticky `error` flag, and sits directly behind the chip-level I/O mapping.

## Interface
Parameters:
- `WIDTH`, 16, sample and result width in bits (≥2).
- `CNT_WIDTH`, 8, sample-counter width in bits (≥1).
- `SIGNED`, 0, 1 = two's-complement comparison; 0 = unsigned.

Ports:
- `clock`  in  1  single clock for the block; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `go`  in  1  start-of-session strobe.
- `finish`  in  1  end-of-session strobe.
- `data_valid`  in  1  qualifies `data_in` in the current cycle.
- `data_in`  in  WIDTH  sample.
- `range`  out  WIDTH  max−min of the last completed session, unsigned.
- `min_out`  out  WIDTH  minimum of the last completed session.
- `max_out`  out  WIDTH  maximum of the last completed session.
- `sample_count`  out  CNT_WIDTH  accepted samples in the last session; saturating.
- `busy`  out  1  high while the session is active.
- `done`  out  1  one-cycle pulse when the results update.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- FSM has 3 states: IDLE, ACTIVE and ERROR. Reset puts it in IDLE.
- Reset values: all outputs are 0. Internal min/max/count accumulators are 0.
- IDLE:
  - `go` & !`finish` → ACTIVE. The accumulators are reinitialised. If `data_valid`, the go-cycle sample seeds min = max = `data_in` and count = 1; otherwise count = 0.
  - `finish` alone, or `go` & `finish` together → ERROR.
- ACTIVE:
  - Each `data_valid` cycle updates min, max and count.
  - The first accepted sample seeds min and max.
  - `go` (with or without `finish`) → ERROR. The session is discarded.
  - `finish` → IDLE. A valid sample on the finish cycle is included. The result registers load and `done` pulses.
- ERROR:
  - `error` = 1. Result outputs hold their last values.
  - `go` & !`finish` clears `error` and starts a new session exactly as from IDLE.
  - All other inputs keep the block in ERROR.
- Comparison uses signed order when `SIGNED`=1, unsigned order otherwise.
- `range` = max − min, computed modulo 2^WIDTH and read as unsigned. The result is exact in both modes because the true difference is at most 2^WIDTH−1.
- Empty session (finish reached with count = 0): `range` = `min_out` = `max_out` = 0, `sample_count` = 0, and `done` still pulses. This is not an error.
- `sample_count` saturates at 2^CNT_WIDTH−1. Min and max keep updating after saturation.
- `data_valid` outside ACTIVE or the go cycle is ignored.

## Timing
- All outputs are registered. There is no combinational input→output path.
- `busy` rises the cycle after the accepted `go`. It falls the cycle after `finish`.
- Results and `done` are visible the cycle after the finish cycle. Latency from the last sample to results is 1 cycle.
- `done` is high for exactly one cycle per completed session. It is never asserted from ERROR.
- `error` rises the cycle after the violating cycle. It clears the cycle after the recovering `go`.
- Back-to-back sessions are allowed: a `go` on the cycle after `finish` is legal.
- Asserting `reset` at any time, including mid-session, immediately clears state and outputs. No `done` is produced for the aborted session.

## Test plan
- Unsigned, WIDTH=8. `go` with 8'h30. Valid samples 8'h10, 8'hF0, 8'h55. `finish` with no valid sample. → Next cycle: `range`=8'hE0, `min_out`=8'h10, `max_out`=8'hF0, `sample_count`=4, `done`=1 for 1 cycle. `busy` was high for 4 cycles.
- SIGNED=1, WIDTH=8. Samples −100, 27, 5, with `finish` on the 5 sample. → `min_out`=8'h9C, `max_out`=8'h1B, `range`=127, `sample_count`=3.
- Gaps in `data_valid` between samples 8'h07 and 8'h03, then an empty finish. → count=2, `range`=4. A following go/finish session with no valid samples → all results 0, `done` pulses.
- Protocol errors:
  - `finish` in IDLE → `error`=1 next cycle; results unchanged.
  - `go` in ACTIVE → `error`=1, no `done`.
  - Recovery `go` with sample 8'h22, then `finish` → `error`=0, `range`=0, count=1.
- CNT_WIDTH=2, 6 valid samples 1..6. → `sample_count`=3 (saturated), `range`=5.
- Assert `reset` mid-session after 3 samples. → All outputs 0 immediately, `busy`=0, no `done`. A new session then works normally.
